conv_tree_sched: RTL and testbench

Scheduler and accumulator for the 3x3 adder tree. It walks output pixels and input channels, fires one window into the tree per cycle when data and output credit allow, and tracks the tree's fixed pipeline latency with tagged tokens. Returning sums are accumulated across channels, and each finished pixel is delivered on a valid/ready stream. The block sits between the window/weight line buffer and the activation writeback.

---
 rtl/conv_sched_pkg.sv | 28 ++
 rtl/conv_tree_sched_sync_fifo.sv | 54 +++++
 rtl/conv_tree_sched.sv | 207 ++++++++++++++++++++
 tb/tb_conv_tree_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared types and default widths for the convolution tree scheduler
//
// Purpose: FSM state encoding, the token carried alongside each window through
// the adder tree, and the default configuration constants.
// Ports: none (package).
package conv_sched_pkg;

  localparam int TREE_LAT_DEF  = 4;
  localparam int SUM_WIDTH_DEF = 20;
  localparam int ACC_WIDTH_DEF = 24;
  localparam int PIX_WIDTH_DEF = 16;
  localparam int CH_WIDTH_DEF  = 8;
  localparam int OUT_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN
  } state_t;

  // first: tree result starts a new pixel sum; last: it completes one
  typedef struct packed {
    logic first;
    logic last;
  } token_t;

endpackage

// File: rtl/conv_tree_sched_sync_fifo.sv
// rtl/conv_tree_sched_sync_fifo.sv - flop-based synchronous result FIFO
//
// Purpose: holds finished pixel sums until the writeback stream takes them.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write side (caller guarantees space)
//   pop, pop_data   read side; pop_data shows the head entry from flops
//   count           number of stored entries
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push && (count != CW'(DEPTH));
  assign pop_ok   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/conv_tree_sched.sv
// rtl/conv_tree_sched.sv - 3x3 adder tree scheduler and channel accumulator
//
// Purpose: walks pixels x channels, fires one window per cycle into the adder
// tree when data and output credit allow, tracks the tree latency with tokens,
// accumulates returning sums across channels and streams finished pixels.
// Optional feature macro: CONV_ACC_SAT_EN (saturating accumulation + sticky ovf).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, num_pix/num_ch job launch and counts (latched in IDLE)
//   busy, done            job status, done is a one-cycle pulse
//   win_valid, win_req    window handshake with the line buffer
//   tree_en, bias_sel     tree load strobe, bias add on channel 0
//   tree_sum              tree result, TREE_LAT cycles after tree_en
//   out_data/valid/ready  pixel result stream
//   ovf                   sticky accumulator saturation flag
module conv_tree_sched
  import conv_sched_pkg::*;
#(
  parameter int TREE_LAT  = TREE_LAT_DEF,
  parameter int SUM_WIDTH = SUM_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int PIX_WIDTH = PIX_WIDTH_DEF,
  parameter int CH_WIDTH  = CH_WIDTH_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [PIX_WIDTH-1:0]        num_pix,
  input  logic [CH_WIDTH-1:0]         num_ch,
  output logic                        busy,
  output logic                        done,
  input  logic                        win_valid,
  output logic                        win_req,
  output logic                        tree_en,
  output logic                        bias_sel,
  input  logic signed [SUM_WIDTH-1:0] tree_sum,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        ovf
);

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  state_t                       state, state_next;
  logic                         done_next;
  logic [PIX_WIDTH-1:0]         pix, num_pix_q;
  logic [CH_WIDTH-1:0]          ch, num_ch_q;
  logic [TREE_LAT-1:0]          tok_v;
  token_t                       tok [TREE_LAT];
  token_t                       ret_tok;
  logic                         ret_v;
  logic                         wr_pend;
  logic signed [ACC_WIDTH-1:0]  acc, acc_next, sum_ext;
  logic [CNT_W-1:0]             fifo_count;
  logic [7:0]                   inflight_last;
  logic                         credit_ok, issue, launch, job_ok;
  logic                         ch_last, pix_last, pop;

  assign launch   = (state == ST_IDLE) && start;
  assign job_ok   = (num_pix != '0) && (num_ch != '0);
  assign ch_last  = (ch == num_ch_q - CH_WIDTH'(1));
  assign pix_last = (pix == num_pix_q - PIX_WIDTH'(1));

  // Every last token still in the tree (or waiting to be written) has a FIFO
  // slot reserved, so returning results never need back-pressure.
  always_comb begin
    inflight_last = 8'(wr_pend);
    for (int i = 0; i < TREE_LAT; i++)
      inflight_last = inflight_last + 8'(tok_v[i] & tok[i].last);
  end

  assign credit_ok = (8'(fifo_count) + inflight_last) < 8'(OUT_DEPTH);
  assign issue     = (state == ST_ISSUE) && win_valid && credit_ok;
  assign tree_en   = issue;
  assign win_req   = issue;
  assign bias_sel  = issue && (ch == '0);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    unique case (state)
      ST_IDLE:  if (start) state_next = job_ok ? ST_ISSUE : ST_FIN;
      ST_ISSUE: if (issue && ch_last && pix_last) state_next = ST_DRAIN;
      ST_DRAIN: if ((tok_v == '0) && !wr_pend) state_next = ST_FIN;
      ST_FIN: begin
        if (fifo_count == '0) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix       <= '0;
      ch        <= '0;
      num_pix_q <= '0;
      num_ch_q  <= '0;
    end else if (launch) begin
      pix       <= '0;
      ch        <= '0;
      num_pix_q <= num_pix;
      num_ch_q  <= num_ch;
    end else if (issue) begin
      if (ch_last) begin
        ch  <= '0;
        pix <= pix + PIX_WIDTH'(1);
      end else begin
        ch  <= ch + CH_WIDTH'(1);
      end
    end
  end

  // Token pipe mirrors the tree: stage TREE_LAT-1 lines up with tree_sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_v <= '0;
      for (int i = 0; i < TREE_LAT; i++) tok[i] <= '0;
    end else begin
      tok_v[0]     <= issue;
      tok[0].first <= (ch == '0);
      tok[0].last  <= ch_last;
      for (int i = 1; i < TREE_LAT; i++) begin
        tok_v[i] <= tok_v[i-1];
        tok[i]   <= tok[i-1];
      end
    end
  end

  assign ret_v   = tok_v[TREE_LAT-1];
  assign ret_tok = tok[TREE_LAT-1];
  assign sum_ext = {{(ACC_WIDTH-SUM_WIDTH){tree_sum[SUM_WIDTH-1]}}, tree_sum};

`ifdef CONV_ACC_SAT_EN
  logic signed [ACC_WIDTH:0] acc_wide;
  logic                      clamp;
  logic                      ovf_q;

  // One guard bit: a sign mismatch between the top two bits means overflow.
  always_comb begin
    acc_wide = {acc[ACC_WIDTH-1], acc} + {sum_ext[ACC_WIDTH-1], sum_ext};
    clamp    = 1'b0;
    acc_next = acc_wide[ACC_WIDTH-1:0];
    if (ret_tok.first) begin
      acc_next = sum_ext;
    end else if (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]) begin
      clamp    = 1'b1;
      acc_next = acc_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || launch) ovf_q <= 1'b0;
    else if (ret_v && clamp) ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign acc_next = ret_tok.first ? sum_ext : acc + sum_ext;
  assign ovf      = 1'b0;
`endif

  // wr_pend lands together with the final acc value, so the FIFO write in the
  // following cycle sees the completed sum even if a new pixel starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      wr_pend <= 1'b0;
    end else begin
      wr_pend <= ret_v && ret_tok.last;
      if (ret_v) acc <= acc_next;
    end
  end

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_pend),
    .push_data (acc),
    .pop       (pop),
    .pop_data  (out_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_conv_tree_sched.sv
// tb/tb_conv_tree_sched.sv - self-checking bench for conv_tree_sched
module tb_conv_tree_sched;

  localparam int TL = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [15:0]        num_pix = '0;
  logic [7:0]         num_ch = '0;
  logic               busy, done, win_req, tree_en, bias_sel, out_valid, ovf;
  logic               win_valid = 1'b0;
  logic               out_ready = 1'b1;
  logic signed [19:0] tree_sum = '0;
  logic signed [23:0] out_data;

  conv_tree_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_pix   (num_pix),
    .num_ch    (num_ch),
    .busy      (busy),
    .done      (done),
    .win_valid (win_valid),
    .win_req   (win_req),
    .tree_en   (tree_en),
    .bias_sel  (bias_sel),
    .tree_sum  (tree_sum),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sum_q[$];
  int exp_q[$];
  logic signed [19:0] ring [8];
  int en_cnt, issue_idx, first_en_cyc, first_val_cyc, done_cyc, done_cnt;
  int valid_cnt, pop_cnt, viol, start_cyc;
  logic [31:0] bias_mask;
  logic hold_pending = 1'b0;
  logic signed [23:0] hold_data;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    en_cnt = 0; issue_idx = 0; first_en_cyc = -1; first_val_cyc = -1;
    done_cyc = -1; valid_cnt = 0; pop_cnt = 0; viol = 0; bias_mask = '0;
  endtask

  // One clock cycle: tree model, protocol monitor and scoreboard, evaluated
  // just after the negedge with this cycle's inputs already applied.
  task automatic step();
    #1;
    cyc++;
    if (win_req !== tree_en) viol++;
    if (bias_sel && !tree_en) viol++;
    if (tree_en) begin
      if (!win_valid) viol++;
      if (bias_sel && issue_idx < 32) bias_mask[issue_idx] = 1'b1;
      issue_idx++;
      en_cnt++;
      if (first_en_cyc < 0) first_en_cyc = cyc;
      ring[(cyc + TL) % 8] = (sum_q.size() > 0) ? 20'(sum_q.pop_front()) : 20'sd0;
    end
    tree_sum = ring[cyc % 8];
    ring[cyc % 8] = 20'h5A5A5;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_valid) begin
      valid_cnt++;
      if (first_val_cyc < 0) first_val_cyc = cyc;
      if (hold_pending) chk("hold_stable", out_data, hold_data);
      if (out_ready) begin
        pop_cnt++;
        hold_pending = 1'b0;
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else chk("out_data", out_data, exp_q.pop_front());
      end else begin
        hold_pending = 1'b1;
        hold_data    = out_data;
      end
    end
    @(negedge clk);
  endtask

  task automatic start_job(input int np, input int nc);
    num_pix = 16'(np);
    num_ch  = 8'(nc);
    start   = 1'b1;
    step();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tree_en"}, tree_en, 0);
    chk({tag, "_win_req"}, win_req, 0);
    chk({tag, "_bias_sel"}, bias_sel, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ring[i] = '0;
    done_cnt = 0;
    clear_stats();
    @(negedge clk);
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // single window, single channel
    clear_stats();
    win_valid = 1'b1; out_ready = 1'b1;
    sum_q = {46}; exp_q = {46};
    start_job(1, 1);
    chk("t1_busy_after_start", busy, 1);
    wait_done("t1_done", 40);
    chk("t1_en_cnt", en_cnt, 1);
    chk("t1_bias_mask", bias_mask, 1);
    chk("t1_latency", first_val_cyc - first_en_cyc, 6);
    chk("t1_pop_cnt", pop_cnt, 1);
    chk("t1_busy_end", busy, 0);

    // two pixels x three channels
    clear_stats();
    sum_q = {10, 20, 30, -5, -5, -5}; exp_q = {60, -15};
    start_job(2, 3);
    wait_done("t2_done", 60);
    chk("t2_en_cnt", en_cnt, 6);
    chk("t2_bias_mask", bias_mask, 32'b001001);
    chk("t2_exp_left", exp_q.size(), 0);

    // output back-pressure: credit stops issue at FIFO depth
    clear_stats();
    out_ready = 1'b0;
    sum_q = {1, 2, 3, 4, 5, 6}; exp_q = {1, 2, 3, 4, 5, 6};
    start_job(6, 1);
    repeat (30) step();
    chk("t3_en_stall", en_cnt, 4);
    chk("t3_busy", busy, 1);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_head", out_data, 1);
    out_ready = 1'b1;
    wait_done("t3_done", 60);
    chk("t3_en_cnt", en_cnt, 6);
    chk("t3_pop_cnt", pop_cnt, 6);
    chk("t3_exp_left", exp_q.size(), 0);

    // sparse windows
    clear_stats();
    win_valid = 1'b0;
    sum_q = {3, 4, 5, 6}; exp_q = {7, 11};
    start_job(2, 2);
    for (int n = 0; n < 60 && done_cyc < 0; n++) begin
      win_valid = (n % 2 == 0);
      step();
    end
    chk("t4_done_seen", done_cyc >= 0, 1);
    chk("t4_en_cnt", en_cnt, 4);
    chk("t4_protocol", viol, 0);
    chk("t4_exp_left", exp_q.size(), 0);

    // zero-count job
    clear_stats();
    win_valid = 1'b1;
    start_job(0, 3);
    chk("t5_busy", busy, 1);
    wait_done("t5_done", 10);
    chk("t5_done_delay", done_cyc - start_cyc, 2);
    chk("t5_en_cnt", en_cnt, 0);

    // start while busy is ignored
    clear_stats();
    win_valid = 1'b0;
    sum_q = {100, -1}; exp_q = {99};
    start_job(1, 2);
    repeat (3) step();
    num_pix = 16'd5; num_ch = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("t6_busy", busy, 1);
    chk("t6_en_idle", en_cnt, 0);
    win_valid = 1'b1;
    wait_done("t6_done", 40);
    chk("t6_en_cnt", en_cnt, 2);
    chk("t6_exp_left", exp_q.size(), 0);

    // accumulator range: 18 x (2^19-1)
    clear_stats();
    sum_q.delete();
    for (int i = 0; i < 18; i++) sum_q.push_back(524287);
`ifdef CONV_ACC_SAT_EN
    exp_q = {8388607};
`else
    exp_q = {-7340050};
`endif
    start_job(1, 18);
    wait_done("t7_done", 80);
`ifdef CONV_ACC_SAT_EN
    chk("t7_ovf", ovf, 1);
`else
    chk("t7_ovf", ovf, 0);
`endif
    chk("t7_exp_left", exp_q.size(), 0);
    start_job(0, 0);
    chk("t7_ovf_cleared", ovf, 0);
    wait_done("t7_zero_done", 10);

    // reset in the middle of a job
    clear_stats();
    sum_q.delete();
    for (int i = 0; i < 16; i++) sum_q.push_back(1);
    exp_q = {4, 4, 4, 4};
    start_job(4, 4);
    repeat (6) step();
    chk("t8_issued", en_cnt > 0, 1);
    rst = 1'b1;
    step();
    check_reset_outputs("t8_rst");
    rst = 1'b0;
    sum_q.delete();
    exp_q.delete();
    hold_pending = 1'b0;
    valid_cnt = 0;
    repeat (20) step();
    chk("t8_no_stale_valid", valid_cnt, 0);
    chk("t8_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
